// File: rtl/spi_cfg_regfile.sv
// spi_cfg_regfile: addressed SPI (mode 0) configuration register file.
//
// The SPI pins are oversampled in the clk domain. Writes land in a shadow copy.
// The shadow is committed to cfg in a single clk after CSn deasserts, so the
// config outputs never change while a frame is being shifted in. Reads return
// the committed cfg.
//
// Frame: command byte {rw, ignored[6:AW], addr[AW-1:0]}, MSB first, followed
// by any number of W-bit data words. The address auto-increments and wraps at
// NREG-1.
//
// Ports:
//   clk        system clock, at least 4x spi_clk
//   rst_n      synchronous active-low reset
//   spi_clk    SPI clock (async)
//   spi_csn    SPI chip select, active low (async)
//   spi_mosi   SPI data in (async)
//   spi_miso   SPI data out, registered in the clk domain
//   cfg        committed registers, packed; register i at [i*W +: W]
//   cfg_update one-clk pulse on the first clk that cfg holds a commit
//   frame_err  sticky error for the last frame, cleared at the next CSn fall
module spi_cfg_regfile #(
  parameter int unsigned       W        = 8,
  parameter int unsigned       NREG     = 8,
  parameter int unsigned       AW       = 3,
  parameter logic [NREG*W-1:0] DEFAULTS = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_csn,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [NREG*W-1:0] cfg,
  output logic              cfg_update,
  output logic              frame_err
);

  localparam int unsigned SW = (W > 8) ? W : 8;  // shifter fits command byte and data word
  localparam int unsigned CW = $clog2(SW);
  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  // [0],[1] synchronise; [2] is the previous value used for edge detection
  logic [2:0]    r_sclk_sync;
  logic [2:0]    r_csn_sync;
  logic [2:0]    r_mosi_sync;

  state_e        r_state;
  logic [CW-1:0] r_bitcnt;
  logic [SW-2:0] r_shift;
  logic          r_rw;
  logic [AW-1:0] r_addr;
  logic          r_addr_bad;
  logic [W-1:0]  r_rd_word;
  logic          r_miso;
  logic [W-1:0]  r_shadow [NREG];
  logic [W-1:0]  r_cfg    [NREG];
  logic [NREG-1:0] r_dirty;
  logic          r_commit;
  logic          r_cfg_update;
  logic          r_frame_err;

  logic          w_sclk_rise;
  logic          w_sclk_fall;
  logic          w_csn_rise;
  logic          w_csn_fall;
  logic          w_mosi;
  logic [SW-1:0] w_shift_in;
  logic [AW-1:0] w_cmd_addr;
  logic          w_cmd_bad;
  logic [AW-1:0] w_addr_inc;
  logic [W-1:0]  w_cmd_rd_word;
  logic [W-1:0]  w_inc_rd_word;

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_csn_rise  = r_csn_sync[1] & ~r_csn_sync[2];
  assign w_csn_fall  = ~r_csn_sync[1] & r_csn_sync[2];
  // MOSI one stage older than the clock rise: the value held just before the edge
  assign w_mosi      = r_mosi_sync[2];

  assign w_shift_in    = {r_shift, w_mosi};
  assign w_cmd_addr    = w_shift_in[AW-1:0];
  assign w_cmd_bad     = 32'(w_cmd_addr) >= NREG;
  assign w_addr_inc    = (r_addr == AW'(NREG - 1)) ? '0 : r_addr + 1'b1;
  assign w_cmd_rd_word = w_cmd_bad ? '0 : r_cfg[IW'(w_cmd_addr)];
  assign w_inc_rd_word = r_cfg[IW'(w_addr_inc)];

  for (genvar gi = 0; gi < NREG; gi++) begin : g_cfg_out
    assign cfg[gi*W +: W] = r_cfg[gi];
  end

  assign spi_miso   = r_miso;
  assign cfg_update = r_cfg_update;
  assign frame_err  = r_frame_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk_sync  <= '0;
      r_csn_sync   <= '1;
      r_mosi_sync  <= '0;
      r_state      <= StIdle;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_addr_bad   <= 1'b0;
      r_rd_word    <= '0;
      r_miso       <= 1'b0;
      r_dirty      <= '0;
      r_commit     <= 1'b0;
      r_cfg_update <= 1'b0;
      r_frame_err  <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        r_shadow[i] <= DEFAULTS[i*W +: W];
        r_cfg[i]    <= DEFAULTS[i*W +: W];
      end
    end else begin
      r_sclk_sync  <= {r_sclk_sync[1:0], spi_clk};
      r_csn_sync   <= {r_csn_sync[1:0], spi_csn};
      r_mosi_sync  <= {r_mosi_sync[1:0], spi_mosi};
      r_cfg_update <= 1'b0;

      if (r_commit) begin
        for (int i = 0; i < NREG; i++) r_cfg[i] <= r_shadow[i];
        r_cfg_update <= 1'b1;
        r_commit     <= 1'b0;
      end

      // CSn rise ends the frame and takes priority over a coincident clock edge
      if (w_csn_rise && (r_state != StIdle)) begin
        r_state  <= StIdle;
        r_miso   <= 1'b0;
        r_commit <= |r_dirty;
        if ((r_state == StCmd) || (r_bitcnt != '0)) r_frame_err <= 1'b1;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_csn_fall) begin
              r_state     <= StCmd;
              r_bitcnt    <= '0;
              r_frame_err <= 1'b0;
              r_dirty     <= '0;
              r_miso      <= 1'b0;
              // A pending commit means the shadow is already newer than cfg
              if (!r_commit) begin
                for (int i = 0; i < NREG; i++) r_shadow[i] <= r_cfg[i];
              end
            end
          end
          StCmd: begin
            if (w_sclk_rise) begin
              r_shift <= w_shift_in[SW-2:0];
              if (r_bitcnt == CW'(7)) begin
                r_state    <= StData;
                r_bitcnt   <= '0;
                r_rw       <= w_shift_in[7];
                r_addr     <= w_cmd_addr;
                r_addr_bad <= w_cmd_bad;
                r_rd_word  <= w_shift_in[7] ? w_cmd_rd_word : '0;
                if (w_cmd_bad) r_frame_err <= 1'b1;
              end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end
          end
          StData: begin
            if (w_sclk_rise) begin
              r_shift <= w_shift_in[SW-2:0];
              if (r_bitcnt == CW'(W - 1)) begin
                r_bitcnt <= '0;
                // An out-of-range start address parks the whole frame
                if (!r_addr_bad) begin
                  if (!r_rw) begin
                    r_shadow[IW'(r_addr)] <= w_shift_in[W-1:0];
                    r_dirty[IW'(r_addr)]  <= 1'b1;
                  end
                  r_addr    <= w_addr_inc;
                  r_rd_word <= r_rw ? w_inc_rd_word : '0;
                end
              end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end else if (w_sclk_fall && r_rw) begin
              r_miso    <= r_rd_word[W-1];
              r_rd_word <= r_rd_word << 1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cfg_regfile.sv
// Testbench for spi_cfg_regfile: SPI master at clk/8, reference register model,
// and queues of expected commits and expected read bytes.
module tb_spi_cfg_regfile;

  localparam int unsigned W    = 8;
  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;
  localparam logic [63:0] DEFAULTS = 64'h0000_0000_1F00_00CC;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        spi_clk  = 1'b0;
  logic        spi_csn  = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [63:0] cfg;
  logic        cfg_update;
  logic        frame_err;

  spi_cfg_regfile #(
    .W       (W),
    .NREG    (NREG),
    .AW      (AW),
    .DEFAULTS(DEFAULTS)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_clk   (spi_clk),
    .spi_csn   (spi_csn),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .cfg       (cfg),
    .cfg_update(cfg_update),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_upd    = 0;
  logic [63:0] model;
  logic [63:0] exp_cfg_q[$];
  logic [7:0]  exp_rd_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] set_reg(input logic [63:0] m, input int i, input logic [7:0] v);
    logic [63:0] r;
    r = m;
    r[i*8 +: 8] = v;
    return r;
  endfunction

  // Every cfg_update pulse must match a commit the bench expects
  always @(negedge clk) begin
    if (rst_n && cfg_update) begin
      n_upd++;
      check_eq("update_expected", 64'(exp_cfg_q.size() != 0), 64'd1);
      if (exp_cfg_q.size() != 0) check_eq("commit_cfg", cfg, exp_cfg_q.pop_front());
    end
  end

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (4) @(negedge clk);
    m = spi_miso;
    spi_clk = 1'b1;
    repeat (4) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], m);
      rx[i] = m;
    end
  endtask

  task automatic cs_low();
    spi_csn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi_csn  = 1'b1;
    spi_mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rx;
    logic       m;
    int         upd0;

    model = DEFAULTS;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("reset_cfg", cfg, DEFAULTS);
    check_eq("reset_update", 64'(cfg_update), 64'd0);
    check_eq("reset_err", 64'(frame_err), 64'd0);
    check_eq("reset_miso", 64'(spi_miso), 64'd0);

    // Read from reg3 across into reg4
    upd0 = n_upd;
    cs_low();
    spi_byte(8'h83, rx);
    exp_rd_q.push_back(model[3*8 +: 8]);
    exp_rd_q.push_back(model[4*8 +: 8]);
    for (int k = 0; k < 2; k++) begin
      spi_byte(8'h00, rx);
      check_eq("read_83", 64'(rx), 64'(exp_rd_q.pop_front()));
    end
    cs_high();
    check_eq("read_83_cfg", cfg, model);
    check_eq("read_83_no_update", 64'(n_upd), 64'(upd0));

    // Two-word write at reg2
    upd0 = n_upd;
    cs_low();
    spi_byte(8'h02, rx);
    spi_byte(8'hA5, rx);
    spi_byte(8'h3C, rx);
    check_eq("write_02_hold", cfg, model);
    model = set_reg(model, 2, 8'hA5);
    model = set_reg(model, 3, 8'h3C);
    exp_cfg_q.push_back(model);
    cs_high();
    check_eq("write_02_updates", 64'(n_upd), 64'(upd0 + 1));
    check_eq("write_02_drained", 64'(exp_cfg_q.size()), 64'd0);
    check_eq("write_02_err", 64'(frame_err), 64'd0);
    check_eq("write_02_cfg", cfg, model);

    // Burst write wrapping 7 -> 0
    upd0 = n_upd;
    cs_low();
    spi_byte(8'h07, rx);
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx);
    model = set_reg(model, 7, 8'h11);
    model = set_reg(model, 0, 8'h22);
    exp_cfg_q.push_back(model);
    cs_high();
    check_eq("wrap_updates", 64'(n_upd), 64'(upd0 + 1));
    check_eq("wrap_cfg", cfg, model);

    // One full word then a 3-bit partial word
    upd0 = n_upd;
    cs_low();
    spi_byte(8'h05, rx);
    spi_byte(8'h77, rx);
    spi_bit(1'b1, m);
    spi_bit(1'b0, m);
    spi_bit(1'b1, m);
    model = set_reg(model, 5, 8'h77);
    exp_cfg_q.push_back(model);
    cs_high();
    check_eq("partial_err", 64'(frame_err), 64'd1);
    check_eq("partial_updates", 64'(n_upd), 64'(upd0 + 1));
    check_eq("partial_cfg", cfg, model);

    // Next frame clears the error; read back committed reg2/reg3
    upd0 = n_upd;
    cs_low();
    check_eq("err_cleared", 64'(frame_err), 64'd0);
    spi_byte(8'h82, rx);
    exp_rd_q.push_back(model[2*8 +: 8]);
    exp_rd_q.push_back(model[3*8 +: 8]);
    for (int k = 0; k < 2; k++) begin
      spi_byte(8'h00, rx);
      check_eq("read_82", 64'(rx), 64'(exp_rd_q.pop_front()));
    end
    cs_high();
    check_eq("read_82_err", 64'(frame_err), 64'd0);
    check_eq("read_82_no_update", 64'(n_upd), 64'(upd0));

    // Reset in the middle of writing 0x55 to reg1
    upd0 = n_upd;
    cs_low();
    spi_byte(8'h01, rx);
    spi_bit(1'b0, m);
    spi_bit(1'b1, m);
    spi_bit(1'b0, m);
    spi_bit(1'b1, m);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model = DEFAULTS;
    spi_bit(1'b0, m);
    spi_bit(1'b1, m);
    spi_bit(1'b0, m);
    spi_bit(1'b1, m);
    cs_high();
    check_eq("midrst_cfg", cfg, DEFAULTS);
    check_eq("midrst_no_update", 64'(n_upd), 64'(upd0));

    // A clean frame after the reset works normally
    upd0 = n_upd;
    cs_low();
    spi_byte(8'h01, rx);
    spi_byte(8'h55, rx);
    model = set_reg(model, 1, 8'h55);
    exp_cfg_q.push_back(model);
    cs_high();
    check_eq("post_rst_updates", 64'(n_upd), 64'(upd0 + 1));
    check_eq("post_rst_cfg", cfg, model);
    check_eq("post_rst_err", 64'(frame_err), 64'd0);
    check_eq("final_drained", 64'(exp_cfg_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
